// File: rtl/prog_loader.sv
// Serial program loader: 12-bit LSB-first frames {data, addr} written into a 16x8 instruction memory.
// Optional sticky framing-error output is enabled by defining LOADER_ERR_EN.
module prog_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [1:0] mode,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [4:0] load_cnt,
    output logic       run_out
`ifdef LOADER_ERR_EN
    ,
    output logic       frame_err
`endif
);

    // state  | meaning
    // IDLE   | waiting for mode 01 (shift) or 11 (run)
    // SHIFT  | collecting frame bits on synchronized sclk rising edges
    // COMMIT | one cycle: memory write, wr_valid pulse
    // RUN    | core enabled, serial inputs ignored
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, RUN} state_t;

    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_RUN   = 2'b11;
    localparam logic [3:0] FRAME_BITS = 4'd12;

    state_t      state;
    logic        sclk_q1, sclk_s, sclk_prev;
    logic        mosi_q1, mosi_s;
    logic [1:0]  mode_q1, mode_s;
    logic [3:0]  bit_cnt;
    logic [11:0] shift_reg;
    logic        overrun;
    logic        sclk_rise;
    logic [7:0]  mem [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q1   <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_q1   <= 1'b0;
            mosi_s    <= 1'b0;
            mode_q1   <= 2'b00;
            mode_s    <= 2'b00;
        end else begin
            sclk_q1   <= sclk;
            sclk_s    <= sclk_q1;
            sclk_prev <= sclk_s;
            mosi_q1   <= mosi;
            mosi_s    <= mosi_q1;
            mode_q1   <= mode;
            mode_s    <= mode_q1;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 12'd0;
            overrun   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= 4'd0;
            wr_data   <= 8'd0;
            load_cnt  <= 5'd0;
            run_out   <= 1'b0;
`ifdef LOADER_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wr_valid <= 1'b0;
                    run_out  <= 1'b0;
                    if (mode_s == MODE_SHIFT) begin
                        state   <= SHIFT;
                        bit_cnt <= 4'd0;
                        overrun <= 1'b0;
                    end else if (mode_s == MODE_RUN) begin
                        state   <= RUN;
                        run_out <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (mode_s == MODE_SHIFT) begin
                        if (sclk_rise) begin
                            if (bit_cnt < FRAME_BITS) begin
                                shift_reg[bit_cnt] <= mosi_s;
                                bit_cnt            <= bit_cnt + 4'd1;
                            end else begin
                                overrun <= 1'b1;
`ifdef LOADER_ERR_EN
                                frame_err <= 1'b1;
`endif
                            end
                        end
                    end else if (bit_cnt == FRAME_BITS && !overrun) begin
                        // Outputs are registered on entry so they are visible during COMMIT.
                        state    <= COMMIT;
                        wr_valid <= 1'b1;
                        wr_addr  <= shift_reg[3:0];
                        wr_data  <= shift_reg[11:4];
                        if (load_cnt != 5'd16)
                            load_cnt <= load_cnt + 5'd1;
                    end else begin
                        state <= IDLE;
`ifdef LOADER_ERR_EN
                        if (bit_cnt != FRAME_BITS)
                            frame_err <= 1'b1;
`endif
                    end
                end
                COMMIT: begin
                    wr_valid <= 1'b0;
                    state    <= IDLE;
                end
                RUN: begin
                    if (mode_s != MODE_RUN) begin
                        state   <= IDLE;
                        run_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wr_valid <= 1'b0;
                    run_out  <= 1'b0;
                end
            endcase
        end
    end

    // Written at the edge ending COMMIT, so a same-cycle read still sees the old byte.
    always_ff @(posedge clk) begin
        if (state == COMMIT)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios with random data against a frame-level model.
// Optional frame_err checks are compiled in when LOADER_ERR_EN is defined.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, mosi;
    logic [1:0] mode;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] load_cnt;
    logic       run_out;
`ifdef LOADER_ERR_EN
    logic       frame_err;
`endif

    prog_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .mode     (mode),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .load_cnt (load_cnt),
        .run_out  (run_out)
`ifdef LOADER_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Reference model: frame-level view of memory and the commit counter.
    logic [7:0] mem_ref [16];
    bit         known   [16];
    int         load_ref = 0;

    always @(negedge clk) if (rst_n === 1'b1 && wr_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit_ref(input logic [3:0] a, input logic [7:0] d);
        mem_ref[a] = d;
        known[a]   = 1'b1;
        load_ref   = (load_ref < 16) ? load_ref + 1 : 16;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            if (known[a]) begin
                @(negedge clk);
                rd_addr = 4'(a);
                #1;
                chk(tag, {24'd0, rd_data}, {24'd0, mem_ref[a]});
            end
        end
    endtask

    task automatic pulse_sclk(input logic b);
        mosi = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Sends nbits edges of frame {d,a}, drops mode, watches up to 8 cycles for wr_valid.
    task automatic send_frame(input logic [3:0] a, input logic [7:0] d, input int nbits,
                              output int lat, output logic [7:0] rd_old, output logic [7:0] rd_new);
        logic [11:0] f;
        f      = {d, a};
        lat    = -1;
        rd_old = 8'h00;
        rd_new = 8'h00;
        @(negedge clk);
        rd_addr = a;
        mode    = 2'b01;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++)
            pulse_sclk((i < 12) ? f[i] : 1'($urandom_range(0, 1)));
        repeat (2) @(negedge clk);
        mode = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (wr_valid === 1'b1 && lat < 0) begin
                lat    = c;
                rd_old = rd_data;
            end else if (lat > 0 && c == lat + 1) begin
                rd_new = rd_data;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mode  = 2'b00;
        sclk  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        load_ref = 0;
        @(negedge clk);
    endtask

    initial begin
        int         lat, p0, c;
        logic [7:0] old_b, new_b, d;
        logic [3:0] a;
        logic [7:0] prev_mem0;

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; mode = 2'b00; rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("reset_wr_addr",  {28'd0, wr_addr},  32'd0);
        chk("reset_wr_data",  {24'd0, wr_data},  32'd0);
        chk("reset_load_cnt", {27'd0, load_cnt}, 32'd0);
        chk("reset_run_out",  {31'd0, run_out},  32'd0);
`ifdef LOADER_ERR_EN
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif

        // Single frame addr 3, data A5
        p0 = pulses;
        send_frame(4'h3, 8'hA5, 12, lat, old_b, new_b);
        commit_ref(4'h3, 8'hA5);
        chk("single_pulses",   32'(pulses - p0), 32'd1);
        chk("single_latency",  {31'd0, (lat >= 1 && lat <= 3)}, 32'd1);
        chk("single_wr_addr",  {28'd0, wr_addr},  32'h3);
        chk("single_wr_data",  {24'd0, wr_data},  32'hA5);
        chk("single_load_cnt", {27'd0, load_cnt}, 32'(load_ref));
        chk("single_rd_next",  {24'd0, new_b},    32'hA5);
        chk("single_run_out",  {31'd0, run_out},  32'd0);

        // 16 frames of random data, then a rewrite of addr 0 with 0x11
        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom_range(0, 255));
            p0 = pulses;
            send_frame(4'(i), d, 12, lat, old_b, new_b);
            commit_ref(4'(i), d);
            chk("fill_pulses",  32'(pulses - p0),   32'd1);
            chk("fill_wr_addr", {28'd0, wr_addr},   32'(i));
            chk("fill_wr_data", {24'd0, wr_data},   {24'd0, d});
            chk("fill_load",    {27'd0, load_cnt},  32'(load_ref));
        end
        prev_mem0 = mem_ref[0];
        send_frame(4'h0, 8'h11, 12, lat, old_b, new_b);
        commit_ref(4'h0, 8'h11);
        chk("rewrite_rd_same_cycle", {24'd0, old_b},    {24'd0, prev_mem0});
        chk("rewrite_rd_next",       {24'd0, new_b},    32'h11);
        chk("rewrite_load_sat",      {27'd0, load_cnt}, 32'd16);
        check_mem("fill_mem");

        // Frame cut after 7 bits
        a  = 4'($urandom_range(0, 15));
        p0 = pulses;
        send_frame(a, 8'($urandom_range(0, 255)), 7, lat, old_b, new_b);
        chk("short_pulses", 32'(pulses - p0),  32'd0);
        chk("short_load",   {27'd0, load_cnt}, 32'(load_ref));
`ifdef LOADER_ERR_EN
        chk("short_frame_err", {31'd0, frame_err}, 32'd1);
`endif
        check_mem("short_mem");

        // 14 rising edges in one frame, from a fresh reset
        do_reset();
`ifdef LOADER_ERR_EN
        chk("rst_frame_err_clear", {31'd0, frame_err}, 32'd0);
`endif
        a  = 4'($urandom_range(0, 15));
        p0 = pulses;
        send_frame(a, 8'($urandom_range(0, 255)), 14, lat, old_b, new_b);
        chk("overrun_pulses", 32'(pulses - p0),  32'd0);
        chk("overrun_load",   {27'd0, load_cnt}, 32'd0);
`ifdef LOADER_ERR_EN
        chk("overrun_frame_err", {31'd0, frame_err}, 32'd1);
`endif
        check_mem("overrun_mem");

        // RUN mode
        @(negedge clk);
        mode = 2'b11;
        c = 0;
        while (run_out !== 1'b1 && c < 8) begin
            @(negedge clk);
            c++;
        end
        chk("run_latency", {31'd0, (c >= 1 && c <= 3)}, 32'd1);
        p0 = pulses;
        for (int i = 0; i < 14; i++) begin
            pulse_sclk(1'($urandom_range(0, 1)));
            chk("run_hold", {31'd0, run_out}, 32'd1);
        end
        chk("run_no_write", 32'(pulses - p0), 32'd0);
        mode = 2'b00;
        c = 0;
        while (run_out !== 1'b0 && c < 8) begin
            @(negedge clk);
            c++;
        end
        chk("run_exit", {31'd0, (c >= 1 && c <= 3)}, 32'd1);
        chk("run_load", {27'd0, load_cnt}, 32'd0);
        check_mem("run_mem");

        // Reset mid-frame after 6 bits, then a full frame addr 5 data 7E
        @(negedge clk);
        mode = 2'b01;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) pulse_sclk(1'($urandom_range(0, 1)));
        do_reset();
        chk("midrst_load",    {27'd0, load_cnt}, 32'd0);
        chk("midrst_wr_addr", {28'd0, wr_addr},  32'd0);
        p0 = pulses;
        send_frame(4'h5, 8'h7E, 12, lat, old_b, new_b);
        commit_ref(4'h5, 8'h7E);
        chk("midrst_pulses",  32'(pulses - p0),  32'd1);
        chk("midrst_load1",   {27'd0, load_cnt}, 32'd1);
        chk("midrst_wr_addr5",{28'd0, wr_addr},  32'h5);
        chk("midrst_wr_data", {24'd0, wr_data},  32'h7E);
`ifdef LOADER_ERR_EN
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
`endif
        check_mem("midrst_mem");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
